// File: rtl/switch_cfg_pkg.sv
// Shared constants, entry layout and FSM states for the switch-matrix configuration loader.
// Entry layout: [2:0] side code, [5:3] source index; entry k lives at cfg_bus[6k+5:6k].
package switch_cfg_pkg;

  localparam int N_TB      = 5;
  localparam int N_LR      = 4;
  localparam int ENTRY_W   = 6;
  localparam int N_ENTRIES = 2*N_TB + 2*N_LR;
  localparam int CFG_W     = N_ENTRIES * ENTRY_W;
  localparam int CSUM_W    = 8;
  localparam logic [7:0] SYNC = 8'hA5;

  localparam int TOP_BASE    = 0;
  localparam int BOTTOM_BASE = TOP_BASE + N_TB;
  localparam int LEFT_BASE   = BOTTOM_BASE + N_TB;
  localparam int RIGHT_BASE  = LEFT_BASE + N_LR;

  localparam logic [2:0] SIDE_OFF    = 3'd0;
  localparam logic [2:0] SIDE_TOP    = 3'd1;
  localparam logic [2:0] SIDE_RIGHT  = 3'd2;
  localparam logic [2:0] SIDE_BOTTOM = 3'd3;
  localparam logic [2:0] SIDE_LEFT   = 3'd4;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_BAD_ENTRY = 2'd1;
  localparam logic [1:0] ERR_CSUM      = 2'd2;

  typedef struct packed {
    logic [2:0] idx;
    logic [2:0] side;
  } entry_t;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LOAD,
    ST_CSUM,
    ST_CHECK,
    ST_COMMIT,
    ST_REJECT
  } state_t;

  // Number of pins on a source side; zero for the off code and for unused codes.
  function automatic logic [2:0] side_pins(input logic [2:0] side);
    logic [2:0] n;
    n = 3'd0;
    case (side)
      SIDE_TOP, SIDE_BOTTOM: n = 3'(N_TB);
      SIDE_RIGHT, SIDE_LEFT: n = 3'(N_LR);
      default:               n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cfg_entry_check.sv
// Combinational validity check of one routing entry (side code and source index in range).
// Shared with the tile self-check logic; no state, zero latency.
module cfg_entry_check
  import switch_cfg_pkg::*;
(
  input  logic [ENTRY_W-1:0] i_entry,
  output logic               o_valid
);

  entry_t w_e;

  assign w_e     = entry_t'(i_entry);
  assign o_valid = (w_e.side == SIDE_OFF) || (w_e.idx < side_pins(w_e.side));

endmodule

// File: rtl/switch_cfg_loader.sv
// Hunts SYNC in a serial stream, deserialises 18 entries + checksum, commits or rejects atomically.
// Commit/reject pulse two cycles after the last checksum bit; in_ready drops only in CHECK and COMMIT/REJECT.
module switch_cfg_loader
  import switch_cfg_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_bit,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic [CFG_W-1:0] o_cfg_bus,
  output logic             o_cfg_update,
  output logic             o_cfg_err,
  output logic [1:0]       o_err_code,
  output logic             o_busy
);

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]         r_sr;
  logic [ENTRY_W-2:0] r_part;
  logic [2:0]         r_bitc;
  logic [4:0]         r_entc;
  logic [CFG_W-1:0]   r_stage;
  logic [7:0]         r_sum;
  logic               r_bad;
  logic [CSUM_W-1:0]  r_csum;
  logic [CFG_W-1:0]   r_cfg_bus;
  logic [1:0]         r_err_code;

  logic               w_rdy;
  logic               w_acc;
  logic [7:0]         w_sr_nxt;
  logic               w_sync_hit;
  logic               w_load_acc;
  logic               w_csum_acc;
  logic               w_ent_done;
  logic               w_load_done;
  logic               w_csum_done;
  logic [ENTRY_W-1:0] w_entry;
  logic               w_entry_ok;
  logic               w_clean;

  assign w_rdy = !((r_state == ST_CHECK) || (r_state == ST_COMMIT) || (r_state == ST_REJECT));
  assign w_acc = i_in_valid && w_rdy;

  assign w_sr_nxt    = {i_in_bit, r_sr[7:1]};
  assign w_sync_hit  = (r_state == ST_HUNT) && w_acc && (w_sr_nxt == SYNC);
  assign w_load_acc  = (r_state == ST_LOAD) && w_acc;
  assign w_csum_acc  = (r_state == ST_CSUM) && w_acc;
  assign w_ent_done  = w_load_acc && (r_bitc == 3'(ENTRY_W-1));
  assign w_load_done = w_ent_done && (r_entc == 5'(N_ENTRIES-1));
  assign w_csum_done = w_csum_acc && (r_bitc == 3'(CSUM_W-1));

  // The 6th bit completes the entry; it is checked in the same cycle it is accepted.
  assign w_entry = {i_in_bit, r_part};
  assign w_clean = !r_bad && (r_csum == r_sum);

  cfg_entry_check u_entry_check (
    .i_entry (w_entry),
    .o_valid (w_entry_ok)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_HUNT:   if (w_sync_hit)  w_state_nxt = ST_LOAD;
      ST_LOAD:   if (w_load_done) w_state_nxt = ST_CSUM;
      ST_CSUM:   if (w_csum_done) w_state_nxt = ST_CHECK;
      ST_CHECK:  w_state_nxt = w_clean ? ST_COMMIT : ST_REJECT;
      ST_COMMIT: w_state_nxt = ST_HUNT;
      ST_REJECT: w_state_nxt = ST_HUNT;
      default:   w_state_nxt = ST_HUNT;
    endcase
  end

  assign o_in_ready   = w_rdy;
  assign o_busy       = (r_state != ST_HUNT);
  assign o_cfg_update = (r_state == ST_COMMIT);
  assign o_cfg_err    = (r_state == ST_REJECT);
  assign o_cfg_bus    = r_cfg_bus;
  assign o_err_code   = r_err_code;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr       <= '0;
      r_part     <= '0;
      r_bitc     <= '0;
      r_entc     <= '0;
      r_stage    <= '0;
      r_sum      <= '0;
      r_bad      <= 1'b0;
      r_csum     <= '0;
      r_cfg_bus  <= '0;
      r_err_code <= ERR_NONE;
    end else begin
      // The window is cleared on a match so the tail of one SYNC can never seed the next hunt.
      if ((r_state == ST_HUNT) && w_acc) begin
        r_sr <= w_sync_hit ? 8'h00 : w_sr_nxt;
      end

      if (w_sync_hit) begin
        r_part  <= '0;
        r_bitc  <= '0;
        r_entc  <= '0;
        r_stage <= '0;
        r_sum   <= '0;
        r_bad   <= 1'b0;
        r_csum  <= '0;
      end

      if (w_load_acc) begin
        r_part <= {i_in_bit, r_part[ENTRY_W-2:1]};
        if (w_ent_done) begin
          r_bitc  <= '0;
          r_entc  <= r_entc + 5'd1;
          r_stage <= {w_entry, r_stage[CFG_W-1:ENTRY_W]};
          r_sum   <= r_sum + 8'(w_entry);
          r_bad   <= r_bad | ~w_entry_ok;
        end else begin
          r_bitc <= r_bitc + 3'd1;
        end
      end

      if (w_csum_acc) begin
        r_csum <= {i_in_bit, r_csum[CSUM_W-1:1]};
        r_bitc <= w_csum_done ? 3'd0 : r_bitc + 3'd1;
      end

      if (r_state == ST_CHECK) begin
        if (w_clean) begin
          r_cfg_bus <= r_stage;
        end else begin
          r_err_code <= r_bad ? ERR_BAD_ENTRY : ERR_CSUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_cfg_loader.sv
// Randomised frame-level bench for switch_cfg_loader against a bit-stream reference model.
`timescale 1ns/1ps
module tb_switch_cfg_loader;
  import switch_cfg_pkg::*;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_in_bit = 1'b0;
  logic             i_in_valid = 1'b0;
  logic             o_in_ready;
  logic [CFG_W-1:0] o_cfg_bus;
  logic             o_cfg_update;
  logic             o_cfg_err;
  logic [1:0]       o_err_code;
  logic             o_busy;

  switch_cfg_loader dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_in_bit     (i_in_bit),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .o_cfg_bus    (o_cfg_bus),
    .o_cfg_update (o_cfg_update),
    .o_cfg_err    (o_cfg_err),
    .o_err_code   (o_err_code),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_mis = 0;
  int low_cnt = 0;

  logic [CFG_W-1:0] exp_bus  = '0;
  logic [1:0]       exp_code = 2'd0;
  logic [5:0]       f_ent [N_ENTRIES];
  logic [7:0]       f_cs;
  bit               gq [$];

  always @(negedge i_clk) if (!o_in_ready) low_cnt++;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic bit entry_ok(input logic [5:0] e);
    int side = int'(e) % 8;
    int idx  = int'(e) / 8;
    if (side == 0) return 1'b1;
    if (side > 4) return 1'b0;
    if (side == 1 || side == 3) return idx <= 4;
    return idx <= 3;
  endfunction

  function automatic logic [7:0] frame_sum();
    int s = 0;
    for (int k = 0; k < N_ENTRIES; k++) s += int'(f_ent[k]);
    return 8'(s % 256);
  endfunction

  function automatic bit sync_only_at_end();
    logic [7:0] w = 8'h00;
    logic [7:0] sy = SYNC;
    bit s [$];
    s = gq;
    for (int i = 0; i < 8; i++) s.push_back(sy[i]);
    for (int i = 0; i < s.size(); i++) begin
      w = {s[i], w[7:1]};
      if (w == sy) return (i == s.size() - 1);
    end
    return 1'b0;
  endfunction

  task automatic make_garbage(input bit fixed);
    bit ok = 1'b0;
    if (fixed) begin
      gq = '{1'b1, 1'b0, 1'b1, 1'b1};
    end else begin
      for (int t = 0; t < 50 && !ok; t++) begin
        gq.delete();
        for (int i = 0; i < int'($urandom_range(12, 1)); i++) gq.push_back(1'($urandom_range(1, 0)));
        ok = sync_only_at_end();
      end
      if (!ok) gq = '{1'b0, 1'b0, 1'b0, 1'b0};
    end
  endtask

  // Called at #1 after a rising edge; returns #1 after the edge that accepted the bit.
  task automatic send_bit(input logic b, input int gap_pct);
    int guard = 0;
    while (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
      i_in_valid = 1'b0;
      @(posedge i_clk); #1;
    end
    i_in_valid = 1'b1;
    i_in_bit   = b;
    while (!o_in_ready && guard < 20) begin
      @(posedge i_clk); #1;
      guard++;
    end
    if (guard >= 20) chk("ready_wait", o_in_ready, 1);
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
  endtask

  task automatic send_prefix(input int gap_pct, input bit fixed);
    logic [7:0] sy = SYNC;
    make_garbage(fixed);
    chk("busy_idle", o_busy, 0);
    foreach (gq[i]) send_bit(gq[i], gap_pct);
    for (int i = 0; i < 7; i++) send_bit(sy[i], gap_pct);
    chk("busy_pre_sync", o_busy, 0);
    send_bit(sy[7], gap_pct);
    chk("busy_rise", o_busy, 1);
  endtask

  task automatic send_frame(input int gap_pct, input bit fixed);
    int start_low = low_cnt;
    bit bad = 1'b0;
    bit ok;
    logic [CFG_W-1:0] nb = '0;
    send_prefix(gap_pct, fixed);
    for (int k = 0; k < N_ENTRIES; k++)
      for (int b = 0; b < 6; b++) send_bit(f_ent[k][b], gap_pct);
    for (int b = 0; b < 8; b++) send_bit(f_cs[b], gap_pct);
    for (int k = 0; k < N_ENTRIES; k++) begin
      if (!entry_ok(f_ent[k])) bad = 1'b1;
      nb[k*6 +: 6] = f_ent[k];
    end
    ok = !bad && (frame_sum() == f_cs);
    if (ok) exp_bus = nb;
    else    exp_code = bad ? 2'd1 : 2'd2;
    chk("n1_ready", o_in_ready, 0);
    chk("n1_busy", o_busy, 1);
    chk("n1_pulse", {o_cfg_update, o_cfg_err}, 2'b00);
    @(posedge i_clk); #1;
    chk("n2_update", o_cfg_update, ok);
    chk("n2_err", o_cfg_err, !ok);
    chk("n2_bus", o_cfg_bus, exp_bus);
    chk("n2_code", o_err_code, exp_code);
    @(posedge i_clk); #1;
    chk("n3_busy", o_busy, 0);
    chk("n3_pulse", {o_cfg_update, o_cfg_err}, 2'b00);
    chk("n3_ready", o_in_ready, 1);
    chk("ready_low_cycles", low_cnt - start_low, 2);
  endtask

  task automatic clear_frame();
    for (int k = 0; k < N_ENTRIES; k++) f_ent[k] = 6'h00;
  endtask

  task automatic gen_random(input int bad_pct, input int cs_err_pct);
    for (int k = 0; k < N_ENTRIES; k++) begin
      int side;
      int idx;
      if (int'($urandom_range(99, 0)) < bad_pct) begin
        f_ent[k] = 6'($urandom_range(63, 0));
      end else begin
        side = int'($urandom_range(4, 0));
        if (side == 0)                    idx = int'($urandom_range(7, 0));
        else if (side == 1 || side == 3)  idx = int'($urandom_range(4, 0));
        else                              idx = int'($urandom_range(3, 0));
        f_ent[k] = 6'(idx * 8 + side);
      end
    end
    f_cs = frame_sum();
    if (int'($urandom_range(99, 0)) < cs_err_pct) f_cs = f_cs ^ 8'(1 << $urandom_range(7, 0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_bus", o_cfg_bus, 0);
    chk("rst_update", o_cfg_update, 0);
    chk("rst_err", o_cfg_err, 0);
    chk("rst_code", o_err_code, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ready", o_in_ready, 1);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    clear_frame(); f_ent[14] = 6'h11; f_cs = 8'h11;
    send_frame(0, 1'b1);
    chk("route_r0", o_cfg_bus[89:84], 6'h11);

    f_cs = 8'h12;
    send_frame(0, 1'b1);

    clear_frame(); f_ent[0] = 6'h05; f_cs = frame_sum();
    send_frame(0, 1'b1);

    clear_frame(); f_ent[10] = 6'h24; f_cs = frame_sum();
    send_frame(0, 1'b1);

    gen_random(0, 0);
    send_frame(0, 1'b0);
    clear_frame(); f_ent[14] = 6'h11; f_cs = 8'h11;
    send_frame(30, 1'b1);
    chk("gap_route_r0", o_cfg_bus[89:84], 6'h11);

    gen_random(0, 0);
    send_prefix(0, 1'b0);
    for (int n = 0; n < 40; n++) send_bit(f_ent[n / 6][n % 6], 0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    exp_bus = '0;
    exp_code = 2'd0;
    chk("midrst_bus", o_cfg_bus, exp_bus);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_ready", o_in_ready, 1);
    chk("midrst_code", o_err_code, exp_code);
    gen_random(0, 0);
    f_ent[14] = 6'h11; f_cs = frame_sum();
    send_frame(0, 1'b0);

    for (int f = 0; f < 16; f++) begin
      gen_random(4, 15);
      send_frame(int'($urandom_range(40, 0)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
